// File: rtl/cluster_pwr_seq.sv
// Cluster power/boot sequencer: timed power, clock, reset and fetch control.
// Optional DRAIN timeout is enabled by defining CLUSTER_PWR_SEQ_TIMEOUT_EN.
//
// Ports:
//   clk_i, rst_ni            SoC clock, async active-low reset
//   pwr_up_req_i             1-cycle request: power up and boot (OFF only)
//   pwr_dn_req_i             1-cycle request: power down (RUN only)
//   boot_addr_i              boot address, latched on accepted up request
//   cluster_busy_i           cluster busy, already synchronised
//   cluster_pow_o            power switch enable
//   cluster_clk_en_o         clock-gate enable
//   cluster_rstn_o           cluster reset, active low
//   cluster_fetch_enable_o   core fetch enable
//   cluster_boot_addr_o      latched boot address
//   ack_o                    pulse on reaching RUN or OFF
//   timeout_o                pulse on DRAIN timeout (0 unless timeout built in)
//   state_o                  current state encoding
`timescale 1ns/1ps
module cluster_pwr_seq #(
  parameter int unsigned PWR_SETTLE_CYC = 16,
  parameter int unsigned RST_HOLD_CYC   = 8,
  parameter int unsigned FETCH_DLY_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC    = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pwr_up_req_i,
  input  logic        pwr_dn_req_i,
  input  logic [63:0] boot_addr_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic        ack_o,
  output logic        timeout_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_ON  = 3'd1,
    S_CLK_ON  = 3'd2,
    S_RST_REL = 3'd3,
    S_RUN     = 3'd4,
    S_DRAIN   = 3'd5,
    S_RST_ASS = 3'd6,
    S_CLK_OFF = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(PWR_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] FETCH_LD  = CNT_W'(FETCH_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD     = CNT_W'(TIMEOUT_CYC - 1);

  // Counter must be able to hold every load value.
  if ((PWR_SETTLE_CYC - 1) >= (1 << CNT_W) ||
      (RST_HOLD_CYC - 1)   >= (1 << CNT_W) ||
      (FETCH_DLY_CYC - 1)  >= (1 << CNT_W) ||
      (TIMEOUT_CYC - 1)    >= (1 << CNT_W)) begin : g_cnt_chk
    $error("CNT_W too small for sequencer delays");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       addr_q, addr_d;
  logic              pow_q, pow_d;
  logic              clk_en_q, clk_en_d;
  logic              rstn_q, rstn_d;
  logic              fetch_q, fetch_d;
  logic              ack_q, ack_d;
  logic              to_q, to_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    to_d    = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (pwr_up_req_i) begin
          state_d = S_PWR_ON;
          addr_d  = boot_addr_i;
        end
      end
      S_PWR_ON:  if (cnt_q == '0) state_d = S_CLK_ON;
      S_CLK_ON:  if (cnt_q == '0) state_d = S_RST_REL;
      S_RST_REL: if (cnt_q == '0) state_d = S_RUN;
      S_RUN:     if (pwr_dn_req_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!cluster_busy_i) begin
          state_d = S_RST_ASS;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          state_d = S_RST_ASS;
          to_d    = 1'b1;
`endif
        end
      end
      S_RST_ASS: if (cnt_q == '0) state_d = S_CLK_OFF;
      S_CLK_OFF: if (cnt_q == '0) state_d = S_OFF;
    endcase

    // Load on entry; otherwise count down and hold at zero.
    if (state_d != state_q) begin
      unique case (state_d)
        S_PWR_ON,
        S_CLK_OFF: cnt_d = SETTLE_LD;
        S_CLK_ON,
        S_RST_ASS: cnt_d = HOLD_LD;
        S_RST_REL: cnt_d = FETCH_LD;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        S_DRAIN:   cnt_d = TO_LD;
`endif
        default:   cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are registered from the next state.
    pow_d    = (state_d != S_OFF);
    clk_en_d = state_d inside {S_CLK_ON, S_RST_REL, S_RUN,
                               S_DRAIN, S_RST_ASS};
    rstn_d   = state_d inside {S_RST_REL, S_RUN, S_DRAIN};
    fetch_d  = (state_d == S_RUN);
    ack_d    = (state_d != state_q) &&
               (state_d == S_RUN || state_d == S_OFF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      addr_q   <= '0;
      pow_q    <= 1'b0;
      clk_en_q <= 1'b0;
      rstn_q   <= 1'b0;
      fetch_q  <= 1'b0;
      ack_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      pow_q    <= pow_d;
      clk_en_q <= clk_en_d;
      rstn_q   <= rstn_d;
      fetch_q  <= fetch_d;
      ack_q    <= ack_d;
      to_q     <= to_d;
    end
  end

  assign cluster_pow_o          = pow_q;
  assign cluster_clk_en_o       = clk_en_q;
  assign cluster_rstn_o         = rstn_q;
  assign cluster_fetch_enable_o = fetch_q;
  assign cluster_boot_addr_o    = addr_q;
  assign ack_o                  = ack_q;
  assign state_o                = state_q;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  assign timeout_o              = to_q;
`else
  assign timeout_o              = 1'b0;
  logic unused_to;
  assign unused_to = to_q ^ (|TO_LD);
`endif

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq.
// Cycle numbers are counted from the edge that samples each request.
`timescale 1ns/1ps
module tb_cluster_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up, dn, busy;
  logic [63:0] baddr_in;
  logic        pow, clk_en, rstn, fetch, ack, tout;
  logic [63:0] baddr;
  logic [2:0]  st;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cluster_pwr_seq dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .pwr_up_req_i           (up),
    .pwr_dn_req_i           (dn),
    .boot_addr_i            (baddr_in),
    .cluster_busy_i         (busy),
    .cluster_pow_o          (pow),
    .cluster_clk_en_o       (clk_en),
    .cluster_rstn_o         (rstn),
    .cluster_fetch_enable_o (fetch),
    .cluster_boot_addr_o    (baddr),
    .ack_o                  (ack),
    .timeout_o              (tout),
    .state_o                (st)
  );

  task automatic tick_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up = 0; dn = 0; busy = 0; baddr_in = '0;
    #3;
    checks++;
    if ({pow, clk_en, rstn, fetch, ack, tout, st} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0",
               {pow, clk_en, rstn, fetch, ack, tout, st});
    end
    checks++;
    if (baddr !== 64'h0) begin
      errors++;
      $display("FAIL reset_baddr got %h want 0", baddr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_power_up(input logic [63:0] a,
                               input bit both, input bit dn_mid);
    up = 1; dn = both; baddr_in = a;
    @(posedge clk); #1;
    cyc = 1; up = 0; dn = 0; baddr_in = ~a;
    checks++;
    if (pow !== 1 || clk_en !== 0 || st !== 3'd1 || baddr !== a) begin
      errors++;
      $display("FAIL up_n1 got pow=%b ce=%b st=%0d ba=%h want 1 0 1 %h",
               pow, clk_en, st, baddr, a);
    end
    if (dn_mid) begin
      tick_to(5); dn = 1;
      tick_to(6); dn = 0;
    end
    tick_to(16);
    checks++;
    if (clk_en !== 0 || st !== 3'd1) begin
      errors++;
      $display("FAIL up_n16 got ce=%b st=%0d want 0 1", clk_en, st);
    end
    tick_to(17);
    checks++;
    if (clk_en !== 1 || rstn !== 0 || st !== 3'd2) begin
      errors++;
      $display("FAIL up_n17 got ce=%b rn=%b st=%0d want 1 0 2",
               clk_en, rstn, st);
    end
    tick_to(24);
    checks++;
    if (rstn !== 0) begin
      errors++;
      $display("FAIL up_n24 got rn=%b want 0", rstn);
    end
    tick_to(25);
    checks++;
    if (rstn !== 1 || fetch !== 0 || st !== 3'd3) begin
      errors++;
      $display("FAIL up_n25 got rn=%b fe=%b st=%0d want 1 0 3",
               rstn, fetch, st);
    end
    tick_to(28);
    checks++;
    if (fetch !== 0 || ack !== 0) begin
      errors++;
      $display("FAIL up_n28 got fe=%b ack=%b want 0 0", fetch, ack);
    end
    tick_to(29);
    checks++;
    if (fetch !== 1 || ack !== 1 || st !== 3'd4 || baddr !== a) begin
      errors++;
      $display("FAIL up_n29 got fe=%b ack=%b st=%0d ba=%h want 1 1 4 %h",
               fetch, ack, st, baddr, a);
    end
    tick_to(30);
    checks++;
    if (ack !== 0 || fetch !== 1) begin
      errors++;
      $display("FAIL up_n30 got ack=%b fe=%b want 0 1", ack, fetch);
    end
  endtask

  task automatic test_ignored_up_in_run(input logic [63:0] a);
    up = 1; baddr_in = 64'hDEAD_BEEF_0000_1234;
    @(posedge clk); #1;
    up = 0;
    @(posedge clk); #1;
    checks++;
    if (st !== 3'd4 || baddr !== a || ack !== 0 || fetch !== 1) begin
      errors++;
      $display("FAIL up_in_run got st=%0d ba=%h ack=%b want 4 %h 0",
               st, baddr, ack, a);
    end
  endtask

  task automatic test_power_down(input int hold, input logic [63:0] a);
    int d;
    d = (hold == 0) ? 1 : hold;
    busy = (hold != 0); dn = 1;
    @(posedge clk); #1;
    cyc = 1; dn = 0;
    checks++;
    if (fetch !== 0 || st !== 3'd5 || rstn !== 1 || ack !== 0) begin
      errors++;
      $display("FAIL dn_m1 got fe=%b st=%0d rn=%b ack=%b want 0 5 1 0",
               fetch, st, rstn, ack);
    end
    if (hold != 0) begin
      tick_to(hold);
      checks++;
      if (st !== 3'd5 || rstn !== 1 || tout !== 0) begin
        errors++;
        $display("FAIL dn_hold got st=%0d rn=%b to=%b want 5 1 0",
                 st, rstn, tout);
      end
      busy = 0;
    end
    tick_to(d + 1);
    checks++;
    if (rstn !== 0 || clk_en !== 1 || st !== 3'd6) begin
      errors++;
      $display("FAIL dn_rst got rn=%b ce=%b st=%0d want 0 1 6",
               rstn, clk_en, st);
    end
    tick_to(d + 8);
    checks++;
    if (clk_en !== 1) begin
      errors++;
      $display("FAIL dn_ce_hold got ce=%b want 1", clk_en);
    end
    tick_to(d + 9);
    checks++;
    if (clk_en !== 0 || pow !== 1 || st !== 3'd7) begin
      errors++;
      $display("FAIL dn_clkoff got ce=%b pow=%b st=%0d want 0 1 7",
               clk_en, pow, st);
    end
    tick_to(d + 24);
    checks++;
    if (pow !== 1 || ack !== 0) begin
      errors++;
      $display("FAIL dn_settle got pow=%b ack=%b want 1 0", pow, ack);
    end
    tick_to(d + 25);
    checks++;
    if (pow !== 0 || ack !== 1 || st !== 3'd0 || baddr !== a) begin
      errors++;
      $display("FAIL dn_off got pow=%b ack=%b st=%0d ba=%h want 0 1 0 %h",
               pow, ack, st, baddr, a);
    end
    tick_to(d + 26);
    checks++;
    if (ack !== 0 || st !== 3'd0) begin
      errors++;
      $display("FAIL dn_after got ack=%b st=%0d want 0 0", ack, st);
    end
  endtask

  task automatic test_reset_mid();
    up = 1; baddr_in = 64'h1C00_8000;
    @(posedge clk); #1;
    cyc = 1; up = 0;
    tick_to(20);
    rst_n = 0;
    #1;
    checks++;
    if ({pow, clk_en, rstn, fetch, ack, st} !== 8'b0 || baddr !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid got %b ba=%h want 0 0",
               {pow, clk_en, rstn, fetch, ack, st}, baddr);
    end
    tick_to(40);
    checks++;
    if (ack !== 0 || st !== 3'd0 || pow !== 0) begin
      errors++;
      $display("FAIL rst_hold got ack=%b st=%0d pow=%b want 0 0 0",
               ack, st, pow);
    end
    rst_n = 1;
    tick_to(42);
    checks++;
    if (st !== 3'd0 || ack !== 0) begin
      errors++;
      $display("FAIL rst_rel got st=%0d ack=%b want 0 0", st, ack);
    end
  endtask

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    busy = 1; dn = 1;
    @(posedge clk); #1;
    cyc = 1; dn = 0;
    tick_to(1024);
    checks++;
    if (tout !== 0 || st !== 3'd5) begin
      errors++;
      $display("FAIL to_pre got to=%b st=%0d want 0 5", tout, st);
    end
    tick_to(1025);
    checks++;
    if (tout !== 1 || st !== 3'd6 || rstn !== 0) begin
      errors++;
      $display("FAIL to_hit got to=%b st=%0d rn=%b want 1 6 0",
               tout, st, rstn);
    end
    tick_to(1026);
    checks++;
    if (tout !== 0) begin
      errors++;
      $display("FAIL to_post got to=%b want 0", tout);
    end
    tick_to(1049);
    checks++;
    if (pow !== 0 || ack !== 1 || st !== 3'd0) begin
      errors++;
      $display("FAIL to_off got pow=%b ack=%b st=%0d want 0 1 0",
               pow, ack, st);
    end
    busy = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_power_up(64'h1C00_8080, 1'b0, 1'b0);
    test_ignored_up_in_run(64'h1C00_8080);
    test_power_down(0, 64'h1C00_8080);
    test_power_up(64'h8000_0000_0000_0100, 1'b0, 1'b1);
    test_power_down(50, 64'h8000_0000_0000_0100);
    test_power_up(64'h0000_0000_1C01_0000, 1'b1, 1'b0);
    test_power_down(0, 64'h0000_0000_1C01_0000);
    test_reset_mid();
    test_power_up(64'h1C00_8080, 1'b0, 1'b0);
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_power_down(0, 64'h1C00_8080);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
